// File: rtl/ukf_matrix_loader.sv
// rtl/ukf_matrix_loader.sv - packs a UKF covariance element stream into header/diag/lower FIFO words
module ukf_matrix_loader #(
    parameter int ELEM_W = 32,
    parameter int FIFO_W = 128,
    parameter int LANES  = FIFO_W / ELEM_W
) (
    input  logic              slow_clock,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [5:0]        cfg_size,
    output logic              cfg_ready,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              wr_enable,
    output logic [FIFO_W-1:0] fifo_in,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              done
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DIAG,
        S_LOWER,
        S_DONE
    } state_t;

    state_t              state;
    logic [5:0]          n;
    logic [10:0]         elem_cnt;
    logic [LANE_W-1:0]   lane_cnt;
    logic [FIFO_W-1:0]   pack;
    logic                pend;
    logic                last_pend;
    logic [FIFO_W-1:0]   pend_word;
    logic [1:0]          pend_phase;

    logic [10:0]         lower_total;
    logic [10:0]         phase_total;
    logic                last_elem;
    logic                lane_full;
    logic                accept;
    logic [FIFO_W-1:0]   pack_next;

    always_comb begin
        // N*(N-1) needs 12 bits at N=63; the halved count fits in 11
        lower_total = 11'((12'(n) * (12'(n) - 12'd1)) >> 1);
        phase_total = (state == S_LOWER) ? lower_total : {5'b0, n};
        last_elem   = (elem_cnt == phase_total - 11'd1);
        lane_full   = (lane_cnt == LANE_W'(LANES - 1));
        in_ready    = ((state == S_DIAG) || (state == S_LOWER)) && !pend && !rst;
        accept      = in_valid && in_ready;
        pack_next   = pack;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                pack_next[k*ELEM_W +: ELEM_W] = in_data;
            end
        end
    end

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge slow_clock) begin
        if (rst) begin
            state      <= S_IDLE;
            n          <= '0;
            elem_cnt   <= '0;
            lane_cnt   <= '0;
            pack       <= '0;
            pend       <= 1'b0;
            last_pend  <= 1'b0;
            pend_word  <= '0;
            pend_phase <= '0;
            wr_enable  <= 1'b0;
            fifo_in    <= '0;
            phase      <= '0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            wr_enable <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_size == 6'd0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            n          <= cfg_size;
                            pend       <= 1'b1;
                            last_pend  <= 1'b1;
                            pend_word  <= FIFO_W'(cfg_size);
                            pend_phase <= 2'd0;
                            elem_cnt   <= '0;
                            lane_cnt   <= '0;
                            pack       <= '0;
                            state      <= S_HEADER;
                        end
                    end
                end
                S_HEADER, S_DIAG, S_LOWER: begin
                    if (pend && !fifo_full) begin
                        fifo_in   <= pend_word;
                        phase     <= pend_phase;
                        wr_enable <= 1'b1;
                        pend      <= 1'b0;
                        last_pend <= 1'b0;
                        // the phase advances only once its final word has left
                        if (last_pend) begin
                            case (state)
                                S_HEADER: state <= S_DIAG;
                                S_DIAG:   state <= (n == 6'd1) ? S_DONE : S_LOWER;
                                default:  state <= S_DONE;
                            endcase
                        end
                    end else if (accept) begin
                        if (lane_full || last_elem) begin
                            pend       <= 1'b1;
                            last_pend  <= last_elem;
                            pend_word  <= pack_next;
                            pend_phase <= (state == S_DIAG) ? 2'd1 : 2'd2;
                            pack       <= '0;
                            lane_cnt   <= '0;
                            elem_cnt   <= last_elem ? 11'd0 : elem_cnt + 11'd1;
                        end else begin
                            pack     <= pack_next;
                            lane_cnt <= lane_cnt + LANE_W'(1);
                            elem_cnt <= elem_cnt + 11'd1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ukf_matrix_loader.sv
// tb/tb_ukf_matrix_loader.sv - randomized self-checking bench for ukf_matrix_loader
module tb_ukf_matrix_loader;
    localparam int EW = 32;
    localparam int FW = 128;
    localparam int L  = FW / EW;

    logic          slow_clock = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [5:0]    cfg_size;
    logic          cfg_ready;
    logic          cfg_err;
    logic          in_valid;
    logic [EW-1:0] in_data;
    logic          in_ready;
    logic          fifo_full;
    logic          wr_enable;
    logic [FW-1:0] fifo_in;
    logic [1:0]    phase;
    logic          busy;
    logic          done;

    ukf_matrix_loader #(.ELEM_W(EW), .FIFO_W(FW), .LANES(L)) dut (
        .slow_clock(slow_clock), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_size(cfg_size), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fifo_full(fifo_full), .wr_enable(wr_enable), .fifo_in(fifo_in), .phase(phase),
        .busy(busy), .done(done)
    );

    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // write monitor: records every strobe and flags any strobe issued while full
    int            cyc = 0;
    int            done_cyc = -1;
    int            full_viol = 0;
    logic          full_q = 1'b0;
    logic [FW-1:0] got_w[$];
    logic [1:0]    got_p[$];
    int            got_c[$];

    always @(posedge slow_clock) full_q <= fifo_full;

    always @(negedge slow_clock) begin
        cyc++;
        if (wr_enable) begin
            got_w.push_back(fifo_in);
            got_p.push_back(phase);
            got_c.push_back(cyc);
            if (full_q) full_viol++;
        end
        if (done) done_cyc = cyc;
    end

    task automatic run_xfer(input int n, input int vpct, input int fpct, input bit stall, input int abort_at);
        logic [EW-1:0] el[$];
        logic [FW-1:0] ew[$];
        logic [1:0]    ep[$];
        logic [FW-1:0] w;
        int  nl;
        int  total;
        int  idx;
        int  budget;
        bit  fin;
        bit  acc;
        bit  stalled;
        nl = n * (n - 1) / 2;
        total = n + nl;
        idx = 0; budget = 0; fin = 0; stalled = 0;
        for (int i = 0; i < total; i++) el.push_back($urandom);
        ew.push_back(FW'(n));
        ep.push_back(2'd0);
        for (int b = 0; b < n; b += L) begin
            w = '0;
            for (int k = 0; k < L; k++) if (b + k < n) w[k*EW +: EW] = el[b + k];
            ew.push_back(w);
            ep.push_back(2'd1);
        end
        for (int b = 0; b < nl; b += L) begin
            w = '0;
            for (int k = 0; k < L; k++) if (b + k < nl) w[k*EW +: EW] = el[n + b + k];
            ew.push_back(w);
            ep.push_back(2'd2);
        end
        got_w.delete(); got_p.delete(); got_c.delete();
        done_cyc = -1;

        @(negedge slow_clock);
        cfg_valid = 1'b1;
        cfg_size  = 6'(n);
        @(posedge slow_clock);
        @(negedge slow_clock);
        cfg_valid = 1'b0;
        check("busy_start", busy, 1);

        while (!fin && budget < 20000) begin
            if (stall && !stalled && idx == L) begin
                stalled   = 1;
                fifo_full = 1'b1;
                in_valid  = 1'b0;
                cfg_valid = 1'b0;
                repeat (5) begin
                    @(posedge slow_clock);
                    @(negedge slow_clock);
                    check("stall_wr", wr_enable, 0);
                    check("stall_rdy", in_ready, 0);
                end
                fifo_full = 1'b0;
                @(posedge slow_clock);
                @(negedge slow_clock);
                check("unstall_wr", wr_enable, 1);
                check("unstall_data", fifo_in, ew[1]);
                check("unstall_phase", phase, 1);
            end
            if (abort_at >= 0 && idx == abort_at) break;
            in_valid = (idx < total) && ($urandom_range(99) < vpct);
            if (idx < total) in_data = el[idx];
            else in_data = $urandom;
            fifo_full = ($urandom_range(99) < fpct);
            cfg_valid = $urandom_range(1);
            cfg_size  = 6'($urandom);
            acc = in_valid && in_ready;
            @(posedge slow_clock);
            if (acc) idx++;
            @(negedge slow_clock);
            budget++;
            if (done) fin = 1;
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        fifo_full = 1'b0;

        if (abort_at >= 0) begin
            check("abort_reached", idx, abort_at);
            rst = 1'b1;
            @(posedge slow_clock);
            @(negedge slow_clock);
            rst = 1'b0;
            check("abort_wr", wr_enable, 0);
            check("abort_data", fifo_in, 0);
            check("abort_phase", phase, 0);
            check("abort_done", done, 0);
            check("abort_err", cfg_err, 0);
            check("abort_rdy", in_ready, 0);
            check("abort_busy", busy, 0);
            check("abort_cfg_ready", cfg_ready, 1);
            repeat (4) @(negedge slow_clock);
            check("abort_no_flush", got_w.size(), 2);
            return;
        end

        #1;
        check("done_seen", fin, 1);
        check("n_writes", got_w.size(), ew.size());
        for (int i = 0; i < ew.size() && i < got_w.size(); i++) begin
            check($sformatf("word%0d_n%0d", i, n), got_w[i], ew[i]);
            check($sformatf("phase%0d_n%0d", i, n), got_p[i], ep[i]);
        end
        if (got_c.size() > 0) check("done_latency", done_cyc, got_c[got_c.size()-1] + 1);
        check("busy_end", busy, 0);
        check("full_respect", full_viol, 0);
    endtask

    initial begin
        int nw;
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_size = '0;
        in_valid = 1'b0;
        in_data = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge slow_clock);
        @(negedge slow_clock);
        check("rst_wr", wr_enable, 0);
        check("rst_data", fifo_in, 0);
        check("rst_phase", phase, 0);
        check("rst_done", done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge slow_clock);
        check("idle_cfg_ready", cfg_ready, 1);

        nw = got_w.size();
        cfg_valid = 1'b1;
        cfg_size  = 6'd0;
        @(posedge slow_clock);
        @(negedge slow_clock);
        cfg_valid = 1'b0;
        check("zero_err", cfg_err, 1);
        check("zero_cfg_ready", cfg_ready, 1);
        check("zero_busy", busy, 0);
        @(negedge slow_clock);
        check("zero_err_pulse", cfg_err, 0);
        repeat (3) @(negedge slow_clock);
        check("zero_no_write", got_w.size(), nw);

        run_xfer(4, 100, 0, 0, -1);
        run_xfer(5, 100, 0, 0, -1);
        run_xfer(1, 100, 0, 0, -1);
        run_xfer(4, 100, 0, 1, -1);
        run_xfer(4, 100, 0, 0, 6);
        run_xfer(2, 100, 0, 0, -1);
        run_xfer(63, 100, 0, 0, -1);
        repeat (8) run_xfer(int'($urandom_range(20, 1)), 70, 30, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ukf_matrix_loader.md
Name: ukf_matrix_loader

Overview:
- Upstream feeder for the UKF Cholesky FIFO controller.
- Takes a matrix size and a stream of scalar covariance elements, then packs the elements into FIFO-width words.
- Emits one header word first (matrix size in bits [5:0]), then the packed diagonal words, then the packed strictly-lower words.
- Drives the single wr_enable/data pair that the controller routes to the diagonal or lower FIFOs, and respects FIFO backpressure.

Parameters:
- ELEM_W, 32: width of one matrix element.
- FIFO_W, 128: FIFO word width. Must be an integer multiple of ELEM_W.
- LANES, FIFO_W/ELEM_W (4): elements packed per FIFO word.

Ports:
- slow_clock  input  1  Sole clock. All state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- cfg_valid  input  1  Size handshake valid.
- cfg_size  input  6  Matrix dimension N.
- cfg_ready  output  1  High only in IDLE.
- cfg_err  output  1  One-cycle pulse when N < 1 is rejected.
- in_valid  input  1  Element stream valid.
- in_data  input  ELEM_W  Element. All N diagonal entries come first (row order), then the lower entries in column-major order, (1,0),(2,0)..(N-1,N-2).
- in_ready  output  1  Element accepted on a cycle where in_valid && in_ready.
- fifo_full  input  1  Downstream FIFO cannot accept a word.
- wr_enable  output  1  Registered one-cycle write strobe.
- fifo_in  output  FIFO_W  Registered data, valid while wr_enable=1.
- phase  output  2  Phase of the word on fifo_in: 0 header, 1 diag, 2 lower.
- busy  output  1  High in every state except IDLE.
- done  output  1  One-cycle pulse after the final word is written.

Behaviour:
- Reset values: wr_enable=0, fifo_in=0, phase=0, done=0, cfg_err=0, in_ready=0, busy=0. Internal state: IDLE, counters=0, pend=0, pack register=0.
- Reset mid-operation drops the transfer: partial pack is discarded, nothing is flushed, and the block returns to IDLE on the next edge.
- States:
  - IDLE -> HEADER on cfg_valid with cfg_size>=1. N is latched.
  - cfg_size=0 while in IDLE: cfg_err pulses, block stays in IDLE.
  - HEADER -> DIAG after the header word is issued.
  - DIAG -> LOWER after the last diagonal word is issued, if N>1.
  - DIAG -> DONE if N==1.
  - LOWER -> DONE after the last lower word is issued.
  - DONE -> IDLE unconditionally; done=1 for that one cycle.
- Counts:
  - Diagonal elements = N.
  - Lower elements = N*(N-1)/2, computed in 11 bits (max 1953 at N=63).
  - Element and lane counters reset at every phase boundary.
- Packing:
  - Element k of a word occupies bits [ELEM_W*k+ELEM_W-1 : ELEM_W*k], lane 0 first.
  - A word completes when all LANES lanes are filled, or when the last element of a phase is accepted.
  - Unused upper lanes of a partial word are zero.
  - Diagonal and lower data never share a word.
- Header word: fifo_in[5:0]=N, all other bits 0, phase=0.
- Handshake:
  - When a word completes, pend=1.
  - in_ready = (state is DIAG or LOWER) && !pend && !rst.
  - On any edge with pend && !fifo_full: fifo_in <= word, wr_enable <= 1, phase updated, pend <= 0.
  - Latency: the strobe appears the cycle after the completing element, or the cycle after fifo_full falls.
  - While fifo_full=1, pend holds and wr_enable stays 0.
  - The header is treated as a pend word on entry to HEADER.
- No two writes occur on consecutive cycles unless the stream allows it. Maximum throughput is one word per LANES+1 cycles.
- in_valid is ignored outside DIAG and LOWER; no element is ever consumed there.
- cfg_valid is ignored while busy.

Test Plan:
- N=4; 10 elements streamed back-to-back with fifo_full=0 -> 4 writes:
  - header 0x...04, phase 0;
  - diag {d3,d2,d1,d0}, phase 1;
  - lower {l3..l0}, phase 2;
  - lower {0,0,l5,l4}, phase 2;
  - then done pulse, busy falls.
- N=5 -> 2 diag words, the second {0,0,0,d4}; 10 lower elements -> 3 lower words, the last {0,0,l9,l8}; 6 writes total.
- N=1 -> header plus one diag word {0,0,0,d0}; LOWER is skipped; done on the cycle after the diag write.
- fifo_full held high for 5 cycles after the first diag word completes:
  - wr_enable stays 0 and in_ready stays 0;
  - fifo_full falls -> wr_enable=1 on the next cycle with data intact, and no element is lost or duplicated.
- cfg_size=0 -> cfg_err pulses for one cycle, cfg_ready stays 1, no write occurs.
- rst asserted for one cycle mid-LOWER with 2 lanes filled -> no flush write, all outputs return to reset values. A new N=2 transfer then yields: header, {0,0,d1,d0}, {0,0,0,l0}.
